// File: rtl/seqdet_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seqdet_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,  // no valid configuration, input ignored
    FILL = 2'd1,  // window not yet holding pat_len bits
    HUNT = 2'd2,  // window full, comparing every valid bit
    HIT  = 2'd3   // match asserted for this cycle
  } state_t;

  localparam int SEQDET_MAX_LEN_DEF = 8;
  localparam int SEQDET_LEN_W_DEF   = 4;
  localparam int SEQDET_COUNT_W_DEF = 16;

endpackage

// File: rtl/seqdet_match_counter.sv
// Saturating match counter; clear wins over hold, but a hit in the clear
// cycle still counts as one.
module seqdet_match_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [COUNT_W-1:0] count_o
);

  logic [COUNT_W-1:0] cnt_q, cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = {{(COUNT_W-1){1'b0}}, inc_i};
    else if (inc_i && (cnt_q != {COUNT_W{1'b1}}))
      cnt_d = cnt_q + COUNT_W'(1);
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector with runtime-loadable pattern (1..MAX_LEN
// bits), overlap/non-overlap mode and a one-cycle match pulse.
// Optional build macro SEQDET_COUNT_EN enables the saturating match counter;
// without it match_count is tied to 0 and cnt_clr is ignored.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = SEQDET_MAX_LEN_DEF,
  parameter int LEN_W   = SEQDET_LEN_W_DEF,
  parameter int COUNT_W = SEQDET_COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic               cfg_err,
  output logic [COUNT_W-1:0] match_count
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, hist_q, hist_d, hist_sh, mask;
  logic [LEN_W-1:0]   len_q, fill_q, fill_d, fill_inc;
  logic               ovl_q, err_q;
  logic               cfg_ok, active, hit;

  assign cfg_ok   = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
  assign active   = (state_q != IDLE);
  assign hist_sh  = {hist_q[MAX_LEN-2:0], din};
  assign fill_inc = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

  // compare only the low pat_len bits of the window
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (LEN_W'(i) < len_q);
  end

  assign hit = active && din_valid && !cfg_load && (fill_inc >= len_q) &&
               (((hist_sh ^ pat_q) & mask) == '0);

  // next state, window and fill; cfg_load overrides and drops that cycle's bit
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (cfg_load) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = cfg_ok ? FILL : IDLE;
    end else if (active) begin
      if (din_valid) begin
        hist_d = hist_sh;
        fill_d = fill_inc;
        if (hit) begin
          state_d = HIT;
          if (!ovl_q) fill_d = '0;  // non-overlap: next match needs fresh bits
        end else begin
          state_d = (fill_inc >= len_q) ? HUNT : FILL;
        end
      end else if (state_q == HIT) begin
        state_d = (fill_q >= len_q) ? HUNT : FILL;
      end
    end
  end

  // FSM state, window and fill registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  // shadow configuration, captured on cfg_load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      err_q <= 1'b0;
    end else if (cfg_load) begin
      pat_q <= pattern;
      len_q <= pat_len;
      ovl_q <= overlap;
      err_q <= !cfg_ok;
    end
  end

  assign match   = (state_q == HIT);
  assign cfg_err = err_q;

`ifdef SEQDET_COUNT_EN
  seqdet_match_counter #(.COUNT_W(COUNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hit),
    .clr_i   (cnt_clr),
    .count_o (match_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; count expectations follow SEQDET_COUNT_EN.
module tb_seq_detector_param;

`ifdef SEQDET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       din = 1'b0, din_valid = 1'b0, cfg_load = 1'b0, overlap = 1'b0, cnt_clr = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic       match, cfg_err;
  logic [3:0] match_count;
  int         n_tests = 0, n_fail = 0;

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .COUNT_W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .match(match), .cfg_err(cfg_err), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // one cycle with cfg_load high; din=1 valid=1 must be dropped
  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic clr);
    pattern = p; pat_len = l; overlap = o; cnt_clr = clr;
    cfg_load = 1'b1; din = 1'b1; din_valid = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; din_valid = 1'b0; cnt_clr = 1'b0;
    chk("load_match", match, 0);
  endtask

  task automatic step(input logic b, input logic v, input logic exp, input string tag);
    @(negedge clk);
    din = b; din_valid = v;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk(tag, match, exp);
  endtask

  // n valid bits, MSB first; exp bit set where match must follow that bit
  task automatic run(input logic [31:0] bits, input logic [31:0] exp, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--)
      step(bits[i], 1'b1, exp[i], tag);
    @(negedge clk) din_valid = 1'b0;
  endtask

  initial begin
    // reset state
    @(posedge clk); #1;
    chk("rst_match", match, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_cnt", match_count, 0);
    rst = 1'b0;
    run(32'b1, 32'b0, 1, "idle_ignore");

    // 1010, non-overlap: hits after bits 4 and 8
    load(8'h0A, 4'd4, 1'b0, 1'b1);
    chk("cfg_ok_err", cfg_err, 0);
    run(32'b1010101010, 32'b0001000100, 10, "nov");
    chk("nov_cnt", match_count, cexp(2));

    // 1010, overlap: hits after 4,6,8,10
    load(8'h0A, 4'd4, 1'b1, 1'b1);
    chk("ovl_clr_cnt", match_count, 0);
    run(32'b1010101010, 32'b0001010101, 10, "ovl");
    chk("ovl_cnt", match_count, cexp(4));

    // 111 with din_valid gaps: hits on valid bits 3,4,5 only
    load(8'h07, 4'd3, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, k >= 3, "gap_valid");
      step(1'b1, 1'b0, 1'b0, "gap_idle");
    end
    chk("gap_cnt", match_count, cexp(3));

    // invalid configs
    load(8'h00, 4'd0, 1'b0, 1'b0);
    chk("len0_err", cfg_err, 1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, "len0_nomatch");
    load(8'hFF, 4'd9, 1'b1, 1'b0);
    chk("len9_err", cfg_err, 1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, "len9_nomatch");
    chk("bad_cnt", match_count, cexp(3));

    // async reset mid-stream
    load(8'h0A, 4'd4, 1'b0, 1'b0);
    chk("reload_err", cfg_err, 0);
    run(32'b101, 32'b000, 3, "pre_rst");
    rst = 1'b1; #2;
    chk("arst_match", match, 0);
    chk("arst_cnt", match_count, 0);
    rst = 1'b0;
    run(32'b1010, 32'b0000, 4, "post_rst_idle");
    load(8'h0A, 4'd4, 1'b0, 1'b0);
    run(32'b0101010, 32'b0000100, 7, "post_rst");

    // full-width pattern, non-overlap back-to-back
    load(8'hCB, 4'd8, 1'b0, 1'b1);
    run(32'hCB, 32'h01, 8, "len8_a");
    run(32'hCB, 32'h01, 8, "len8_b");
    chk("len8_cnt", match_count, cexp(2));

    // len 1, 20 overlapping hits saturate a 4-bit counter
    load(8'h01, 4'd1, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b1, "sat_hit");
    chk("sat_cnt", match_count, cexp(15));
    step(1'b0, 1'b1, 1'b0, "sat_miss");
    chk("sat_hold", match_count, cexp(15));
    cnt_clr = 1'b1;
    step(1'b1, 1'b1, 1'b1, "clr_hit");
    chk("clr_hit_cnt", match_count, cexp(1));
    step(1'b1, 1'b0, 1'b0, "hit_drop");
    chk("hit_drop_cnt", match_count, cexp(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
